// File: rtl/quiz_buzz_if.sv
// quiz_buzz_if: host/player button inputs and judgement/display outputs of the quiz arbiter
interface quiz_buzz_if;
  logic       start;
  logic [3:0] btn;
  logic       judge_yes;
  logic       judge_no;
  logic       endgame;
  logic [3:0] who;
  logic       yes;
  logic       no;
  logic [2:0] state;
  logic [7:0] countdown;
  logic [3:0] foul;
  modport master (output start, btn, judge_yes, judge_no, endgame,
                  input who, yes, no, state, countdown, foul);
  modport slave (input start, btn, judge_yes, judge_no, endgame,
                 output who, yes, no, state, countdown, foul);
endinterface

// File: rtl/quiz_buzz_arbiter.sv
// quiz_buzz_arbiter: synchronises buttons, locks the first eligible buzzer, runs BCD countdowns
module quiz_buzz_arbiter #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int ARM_SEC    = 20,
  parameter int ANSWER_SEC = 10,
  parameter int PULSE_CYC  = 8
) (
  input logic       clk,
  input logic       rst,
  quiz_buzz_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, ARMED = 3'd1, LOCKED = 3'd2, RESULT = 3'd3, OVER = 3'd4} state_t;
  localparam int TW = $clog2(TICK_DIV);
  localparam int PW = PULSE_CYC > 1 ? $clog2(PULSE_CYC) : 1;
  localparam logic [7:0] ARM_BCD = 8'((ARM_SEC / 10) * 16 + ARM_SEC % 10);
  localparam logic [7:0] ANS_BCD = 8'((ANSWER_SEC / 10) * 16 + ANSWER_SEC % 10);

  state_t        r_state, w_next;
  logic [6:0]    r_s1, r_s2, r_s3, r_edge;
  logic [TW-1:0] r_tick;
  logic [PW-1:0] r_pcnt;
  logic [7:0]    r_cd;
  logic [3:0]    r_who, r_foul;
  logic          r_isyes, r_eg;
  logic [3:0]    w_btn, w_elig, w_idx;
  logic          w_start, w_jy, w_jn, w_wrap, w_zero, w_done, w_count;
  logic [7:0]    w_dec;

  assign w_btn   = r_edge[3:0];
  assign w_start = r_edge[4];
  assign w_jy    = r_edge[5];
  assign w_jn    = r_edge[6];
  assign w_elig  = w_btn & ~r_foul;
  assign w_idx   = w_elig[0] ? 4'd1 : w_elig[1] ? 4'd2 : w_elig[2] ? 4'd3 : w_elig[3] ? 4'd4 : 4'd0;
  assign w_count = r_state == ARMED || r_state == LOCKED;
  assign w_wrap  = w_count && r_tick == TW'(TICK_DIV - 1);
  assign w_zero  = r_cd == 8'h00;
  assign w_done  = r_pcnt == PW'(PULSE_CYC - 1);
  assign w_dec   = r_cd[3:0] == 4'd0 ? {r_cd[7:4] - 4'd1, 4'd9} : {r_cd[7:4], r_cd[3:0] - 4'd1};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.endgame ? OVER : w_start ? ARMED : IDLE;
      ARMED:   w_next = bus.endgame ? OVER : w_zero ? IDLE : |w_elig ? LOCKED : ARMED;
      LOCKED:  w_next = bus.endgame ? OVER : (w_zero || (w_jy ^ w_jn)) ? RESULT : LOCKED;
      RESULT:  w_next = w_done ? ((r_eg || bus.endgame) ? OVER : IDLE) : RESULT;
      default: w_next = OVER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_s1    <= '0;
      r_s2    <= '0;
      r_s3    <= '0;
      r_edge  <= '0;
      r_tick  <= '0;
      r_pcnt  <= '0;
      r_cd    <= '0;
      r_who   <= '0;
      r_foul  <= '0;
      r_isyes <= 1'b0;
      r_eg    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_s1    <= {bus.judge_no, bus.judge_yes, bus.start, bus.btn};
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_edge  <= r_s2 & ~r_s3;
      r_tick  <= (w_next != r_state || !w_count || w_wrap) ? '0 : r_tick + 1'b1;
      r_pcnt  <= r_state == RESULT ? r_pcnt + 1'b1 : '0;
      r_eg    <= r_state == RESULT && (r_eg || bus.endgame);
      r_foul  <= (r_state == RESULT && w_done) ? 4'd0 : r_state == IDLE ? r_foul | w_btn : r_foul;
      if (r_state == LOCKED && w_next == RESULT)
        r_isyes <= !w_zero && w_jy;
      // reloads take precedence over a coincident tick-wrap decrement
      if (r_state == IDLE && w_next == ARMED) begin
        r_cd  <= ARM_BCD;
        r_who <= 4'd0;
      end else if (r_state == ARMED && w_next == LOCKED) begin
        r_cd  <= ANS_BCD;
        r_who <= w_idx;
      end else if (w_wrap && !w_zero) begin
        r_cd <= w_dec;
      end
    end
  end

  assign bus.who       = r_who;
  assign bus.yes       = r_state == RESULT && r_isyes;
  assign bus.no        = r_state == RESULT && !r_isyes;
  assign bus.state     = r_state;
  assign bus.countdown = r_cd;
  assign bus.foul      = r_foul;
endmodule

// File: tb/tb_quiz_buzz_arbiter.sv
// tb_quiz_buzz_arbiter: directed table, corner sequences and a randomized model comparison
module tb_quiz_buzz_arbiter;
  localparam int TD = 4, ARM0 = 3, ANS0 = 10, PC = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0, n_total = 0;

  quiz_buzz_if b0();
  quiz_buzz_if b1();
  assign b1.start     = b0.start;
  assign b1.btn       = b0.btn;
  assign b1.judge_yes = b0.judge_yes;
  assign b1.judge_no  = b0.judge_no;
  assign b1.endgame   = b0.endgame;

  quiz_buzz_arbiter #(.TICK_DIV(TD), .ARM_SEC(ARM0), .ANSWER_SEC(ANS0), .PULSE_CYC(PC))
    u0 (.clk(clk), .rst(rst), .bus(b0));
  quiz_buzz_arbiter #(.TICK_DIV(TD), .ARM_SEC(12), .ANSWER_SEC(2), .PULSE_CYC(PC))
    u1 (.clk(clk), .rst(rst), .bus(b1));

  always #5 clk = ~clk;

  typedef struct {
    logic st; logic [3:0] btn; logic jy; logic jn; int n;
    logic [2:0] e_st; logic [3:0] e_who; logic e_y; logic e_n; logic [7:0] e_cd; logic [3:0] e_f;
  } vec_t;
  vec_t tv[5];

  function automatic logic [20:0] ob(input logic [2:0] st, input logic [3:0] who, input logic y,
                                     input logic n, input logic [7:0] cd, input logic [3:0] f);
    return {st, who, y, n, cd, f};
  endfunction
  function automatic logic [20:0] obs0();
    return ob(b0.state, b0.who, b0.yes, b0.no, b0.countdown, b0.foul);
  endfunction
  function automatic logic [20:0] obs1();
    return ob(b1.state, b1.who, b1.yes, b1.no, b1.countdown, b1.foul);
  endfunction

  task automatic chk(input string nm, input logic [20:0] got, input logic [20:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got st=%0d who=%0d y=%b n=%b cd=%h foul=%b, want st=%0d who=%0d y=%b n=%b cd=%h foul=%b",
                  nm, got[20:18], got[17:14], got[13], got[12], got[11:4], got[3:0],
                  exp[20:18], exp[17:14], exp[13], exp[12], exp[11:4], exp[3:0]);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic drive(input logic st, input logic [3:0] btn, input logic jy, input logic jn);
    b0.start = st; b0.btn = btn; b0.judge_yes = jy; b0.judge_no = jn;
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 0); b0.endgame = 0; rst = 1; cyc(2); rst = 0;
  endtask

  // reference model: integer seconds, remaining-pulse count, 4-deep input history
  int m_st, m_cd, m_tick, m_left, m_who;
  logic [3:0] m_foul;
  logic m_y, m_eg;
  logic [6:0] h[4];

  task automatic m_step(input logic [6:0] in, input logic eg, input logic r);
    logic [6:0] e; logic [3:0] b, el; int old_cd, nst; logic wrap;
    if (r) begin
      m_st = 0; m_cd = 0; m_tick = 0; m_left = 0; m_who = 0; m_foul = 0; m_y = 0; m_eg = 0;
      for (int i = 0; i < 4; i++) h[i] = '0;
      return;
    end
    e = h[2] & ~h[3];
    h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = in;
    b = e[3:0]; el = b & ~m_foul;
    wrap = (m_st == 1 || m_st == 2) && m_tick == TD - 1;
    old_cd = m_cd;
    if (wrap && m_cd > 0) m_cd--;
    nst = m_st;
    case (m_st)
      0: begin
        m_foul |= b;
        if (eg) nst = 4;
        else if (e[4]) begin nst = 1; m_cd = ARM0; m_who = 0; end
      end
      1: if (eg) nst = 4;
         else if (old_cd == 0) nst = 0;
         else if (el != 0) begin
           nst = 2; m_cd = ANS0;
           for (int i = 3; i >= 0; i--) if (el[i]) m_who = i + 1;
         end
      2: if (eg) nst = 4;
         else if (old_cd == 0) begin nst = 3; m_y = 0; m_left = PC; end
         else if (e[5] != e[6]) begin nst = 3; m_y = e[5]; m_left = PC; end
      3: begin
        m_eg = m_eg | eg; m_left--;
        if (m_left == 0) begin nst = m_eg ? 4 : 0; m_foul = 0; end
      end
      default: ;
    endcase
    if (nst != 3) m_eg = 0;
    m_tick = (nst != m_st || !(nst == 1 || nst == 2) || wrap) ? 0 : m_tick + 1;
    m_st = nst;
  endtask

  function automatic logic [20:0] m_obs();
    return ob(3'(m_st), 4'(m_who), m_st == 3 && m_y, m_st == 3 && !m_y,
              8'((m_cd / 10) * 16 + m_cd % 10), m_foul);
  endfunction

  initial begin
    logic [6:0] r_in; logic eg, r; int over_cnt;
    drive(0, 0, 0, 0); b0.endgame = 0;
    cyc(2); rst = 0;

    tv[0] = '{1'b0, 4'h0, 1'b0, 1'b0, 1, 3'd0, 4'd0, 1'b0, 1'b0, 8'h00, 4'h0};
    tv[1] = '{1'b1, 4'h0, 1'b0, 1'b0, 4, 3'd1, 4'd0, 1'b0, 1'b0, 8'h03, 4'h0};
    tv[2] = '{1'b0, 4'h4, 1'b0, 1'b0, 4, 3'd2, 4'd3, 1'b0, 1'b0, 8'h10, 4'h0};
    tv[3] = '{1'b0, 4'h0, 1'b0, 1'b0, 1, 3'd2, 4'd3, 1'b0, 1'b0, 8'h10, 4'h0};
    tv[4] = '{1'b0, 4'h0, 1'b1, 1'b0, 4, 3'd3, 4'd3, 1'b1, 1'b0, 8'h09, 4'h0};
    for (int i = 0; i < 5; i++) begin
      drive(tv[i].st, tv[i].btn, tv[i].jy, tv[i].jn);
      cyc(tv[i].n);
      chk($sformatf("vec%0d", i), obs0(),
          ob(tv[i].e_st, tv[i].e_who, tv[i].e_y, tv[i].e_n, tv[i].e_cd, tv[i].e_f));
    end
    drive(0, 0, 0, 0);
    for (int i = 1; i < PC; i++) begin cyc(1); chk("yes_hold", obs0(), ob(3, 3, 1, 0, 8'h09, 0)); end
    cyc(1); chk("yes_end", obs0(), ob(0, 3, 0, 0, 8'h09, 0));

    drive(1, 0, 0, 0); cyc(4); chk("t2_arm", obs0(), ob(1, 0, 0, 0, 8'h03, 0));
    drive(0, 4'h9, 0, 0); cyc(4); chk("t2_lowest", obs0(), ob(2, 1, 0, 0, 8'h10, 0));
    drive(0, 0, 1, 1); cyc(4); chk("t2_both_a", obs0(), ob(2, 1, 0, 0, 8'h09, 0));
    cyc(4); chk("t2_both_b", obs0(), ob(2, 1, 0, 0, 8'h08, 0));

    do_reset();
    drive(0, 4'h2, 0, 0); cyc(4); chk("t3_foul", obs0(), ob(0, 0, 0, 0, 8'h00, 4'h2));
    drive(0, 0, 0, 0); cyc(2);
    drive(1, 4'h2, 0, 0); cyc(4); chk("t3_start", obs0(), ob(1, 0, 0, 0, 8'h03, 4'h2));
    drive(0, 0, 0, 0); cyc(2);
    drive(0, 4'h2, 0, 0); cyc(4); chk("t3_ignored", obs0(), ob(1, 0, 0, 0, 8'h02, 4'h2));
    drive(0, 4'h8, 0, 0); cyc(4); chk("t3_lock4", obs0(), ob(2, 4, 0, 0, 8'h10, 4'h2));
    drive(0, 0, 0, 1); cyc(4); chk("t3_no", obs0(), ob(3, 4, 0, 1, 8'h09, 4'h2));
    drive(0, 0, 0, 0); cyc(8); chk("t3_clear", obs0(), ob(0, 4, 0, 0, 8'h09, 4'h0));

    do_reset();
    drive(1, 0, 0, 0); cyc(4); chk("t5_12", obs1(), ob(1, 0, 0, 0, 8'h12, 0));
    drive(0, 0, 0, 0); cyc(4); chk("t5_11", obs1(), ob(1, 0, 0, 0, 8'h11, 0));
    cyc(4); chk("t5_10", obs1(), ob(1, 0, 0, 0, 8'h10, 0));
    cyc(4); chk("t5_09", obs1(), ob(1, 0, 0, 0, 8'h09, 0));
    cyc(36); chk("t5_00", obs1(), ob(1, 0, 0, 0, 8'h00, 0));
    cyc(1); chk("t5_idle", obs1(), ob(0, 0, 0, 0, 8'h00, 0));

    do_reset();
    drive(1, 0, 0, 0); cyc(4);
    drive(0, 4'h1, 0, 0); cyc(4); chk("t4_lock", obs1(), ob(2, 1, 0, 0, 8'h02, 0));
    drive(0, 0, 0, 0); cyc(4); chk("t4_01", obs1(), ob(2, 1, 0, 0, 8'h01, 0));
    cyc(4); chk("t4_00", obs1(), ob(2, 1, 0, 0, 8'h00, 0));
    for (int i = 0; i < PC; i++) begin cyc(1); chk("t4_no", obs1(), ob(3, 1, 0, 1, 8'h00, 0)); end
    cyc(1); chk("t4_end", obs1(), ob(0, 1, 0, 0, 8'h00, 0));

    do_reset();
    b0.endgame = 1; cyc(1); chk("eg_idle", obs0(), ob(4, 0, 0, 0, 8'h00, 0));
    do_reset();
    drive(1, 0, 0, 0); cyc(4);
    drive(0, 4'h1, 0, 0); cyc(4);
    drive(0, 0, 1, 0); cyc(4); chk("t6_yes", obs0(), ob(3, 1, 1, 0, 8'h09, 0));
    drive(0, 0, 0, 0);
    for (int i = 1; i < PC; i++) begin
      if (i == 3) b0.endgame = 1;
      cyc(1); chk("t6_hold", obs0(), ob(3, 1, 1, 0, 8'h09, 0));
    end
    cyc(1); chk("t6_over", obs0(), ob(4, 1, 0, 0, 8'h09, 0));
    b0.endgame = 0; drive(1, 0, 0, 0); cyc(4); chk("t6_stuck", obs0(), ob(4, 1, 0, 0, 8'h09, 0));
    rst = 1; cyc(1); chk("t6_rst", obs0(), ob(0, 0, 0, 0, 8'h00, 0));
    rst = 0; drive(0, 0, 0, 0);

    r_in = '0; eg = 0; over_cnt = 0;
    rst = 1; m_step(r_in, eg, 1); cyc(1);
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 7) == 0) r_in[i] = ~r_in[i];
      if ($urandom_range(0, 9) == 0) r_in[4] = ~r_in[4];
      for (int i = 5; i < 7; i++) if ($urandom_range(0, 24) == 0) r_in[i] = ~r_in[i];
      if (!eg && $urandom_range(0, 299) == 0) eg = 1;
      r = ($urandom_range(0, 249) == 0) || over_cnt > 12;
      if (r) eg = 0;
      drive(r_in[4], r_in[3:0], r_in[5], r_in[6]); b0.endgame = eg; rst = r;
      m_step(r_in, eg, r);
      cyc(1);
      over_cnt = m_st == 4 ? over_cnt + 1 : 0;
      chk("rand", obs0(), m_obs());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
